// File: rtl/bf_job_ctrl_if.sv
// Job bus between the system side (master) and bf_job_ctrl (slave).
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both high. The sender holds valid and its payload stable until that edge.
// Ready never depends combinationally on valid.
interface bf_job_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [63:0] in_key;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_mode;
  logic        out_err;

  modport master (
    output in_valid, in_mode, in_key, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_mode, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_key, in_data, out_ready,
    output in_ready, out_valid, out_data, out_mode, out_err
  );
endinterface

// File: rtl/bf_job_ctrl.sv
// Job sequencer in front of the blowfish core, with a saturating watchdog on every core pass.
// Optional encrypt round-trip verification is enabled by defining BF_ROUNDTRIP_CHECK_EN.
module bf_job_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  bf_job_ctrl_if.slave job,
  output logic         core_start,
  output logic         core_enc,
  output logic         core_dec,
  output logic [63:0]  core_key,
  output logic [63:0]  core_text,
  input  logic [63:0]  core_encryptedtext,
  input  logic [63:0]  core_decryptedtext,
  input  logic         core_encrypt_done,
  input  logic         core_decrypt_done,
  output logic [2:0]   dbg_state
);

  localparam logic [15:0] TIMEOUT_LIM = TIMEOUT_CYCLES[15:0];

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    VLAUNCH = 3'd3,
    VWAIT   = 3'd4,
    HOLD    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] wd_q, wd_d, wd_inc;
  logic [63:0] key_q, key_d;
  logic [63:0] text_q, text_d;
  logic [63:0] out_data_q, out_data_d;
  logic        mode_q, mode_d;
  logic        out_err_q, out_err_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        enc_q, enc_d;
  logic        dec_q, dec_d;
  logic        done_sel, flags_low, wd_expired;
`ifdef BF_ROUNDTRIP_CHECK_EN
  logic [63:0] ptxt_q, ptxt_d;
`endif

  assign wd_inc     = (wd_q == 16'hffff) ? wd_q : wd_q + 16'd1;
  assign wd_expired = (wd_inc >= TIMEOUT_LIM);
  assign done_sel   = mode_q ? core_decrypt_done : core_encrypt_done;
  // Launch only once the core has dropped any done left over from an earlier pass.
  assign flags_low  = ~core_encrypt_done & ~core_decrypt_done;

  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    key_d      = key_q;
    text_d     = text_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    core_start = 1'b0;
`ifdef BF_ROUNDTRIP_CHECK_EN
    ptxt_d     = ptxt_q;
`endif
    case (state_q)
      IDLE: begin
        if (job.in_valid && in_ready_q) begin
          key_d   = job.in_key;
          text_d  = job.in_data;
          mode_d  = job.in_mode;
`ifdef BF_ROUNDTRIP_CHECK_EN
          ptxt_d  = job.in_data;
`endif
          state_d = LAUNCH;
        end
      end
      LAUNCH, VLAUNCH: begin
        if (flags_low) begin
          core_start = 1'b1;
          wd_d       = 16'd0;
          state_d    = (state_q == LAUNCH) ? WAIT : VWAIT;
        end
      end
      WAIT: begin
        wd_d = wd_inc;
        if (done_sel) begin
          out_err_d = 1'b0;
          if (mode_q) begin
            out_data_d = core_decryptedtext;
            state_d    = HOLD;
          end else begin
            out_data_d = core_encryptedtext;
`ifdef BF_ROUNDTRIP_CHECK_EN
            text_d     = core_encryptedtext;
            state_d    = VLAUNCH;
`else
            state_d    = HOLD;
`endif
          end
        end else if (wd_expired) begin
          out_data_d = 64'd0;
          out_err_d  = 1'b1;
          state_d    = HOLD;
        end
      end
`ifdef BF_ROUNDTRIP_CHECK_EN
      VWAIT: begin
        wd_d = wd_inc;
        if (core_decrypt_done) begin
          out_err_d = (core_decryptedtext != ptxt_q);
          state_d   = HOLD;
        end else if (wd_expired) begin
          out_err_d = 1'b1;
          state_d   = HOLD;
        end
      end
`endif
      HOLD: begin
        if (job.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == HOLD);
    enc_d       = ~mode_d & ((state_d == LAUNCH) | (state_d == WAIT));
    dec_d       = (mode_d & ((state_d == LAUNCH) | (state_d == WAIT)))
                | (state_d == VLAUNCH) | (state_d == VWAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wd_q        <= 16'd0;
      key_q       <= 64'd0;
      text_q      <= 64'd0;
      mode_q      <= 1'b0;
      out_data_q  <= 64'd0;
      out_err_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      enc_q       <= 1'b0;
      dec_q       <= 1'b0;
`ifdef BF_ROUNDTRIP_CHECK_EN
      ptxt_q      <= 64'd0;
`endif
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      key_q       <= key_d;
      text_q      <= text_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      enc_q       <= enc_d;
      dec_q       <= dec_d;
`ifdef BF_ROUNDTRIP_CHECK_EN
      ptxt_q      <= ptxt_d;
`endif
    end
  end

  assign job.in_ready  = in_ready_q;
  assign job.out_valid = out_valid_q;
  assign job.out_data  = out_data_q;
  assign job.out_mode  = mode_q;
  assign job.out_err   = out_err_q;
  assign core_enc      = enc_q;
  assign core_dec      = dec_q;
  assign core_key      = key_q;
  assign core_text     = text_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_bf_job_ctrl.sv
// Directed bench for bf_job_ctrl: two instances (long and short watchdog) each driving an XOR core model.
module tb_bf_job_ctrl;

  localparam logic [63:0] K  = 64'hcade514815fde3a8;
  localparam logic [63:0] P  = 64'h0123456789abcdef;
  localparam logic [63:0] C  = 64'hcbfd142f9c562e47;
  localparam logic [63:0] K2 = 64'hffffffff00000000;
  localparam logic [63:0] R2 = 64'hfedcba9889abcdef;
`ifdef BF_ROUNDTRIP_CHECK_EN
  localparam int ENC_LAT = 35;
`else
  localparam int ENC_LAT = 18;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  bf_job_ctrl_if ja();
  bf_job_ctrl_if jb();

  logic        a_start, a_enc, a_dec, a_edone, a_ddone;
  logic [63:0] a_key, a_text, a_etxt, a_dtxt;
  logic [2:0]  a_state;
  logic        b_start, b_enc, b_dec, b_edone, b_ddone;
  logic [63:0] b_key, b_text, b_etxt, b_dtxt;
  logic [2:0]  b_state;

  bf_job_ctrl #(.TIMEOUT_CYCLES(1024)) dut_a (
    .clk(clk), .rst(rst), .job(ja),
    .core_start(a_start), .core_enc(a_enc), .core_dec(a_dec),
    .core_key(a_key), .core_text(a_text),
    .core_encryptedtext(a_etxt), .core_decryptedtext(a_dtxt),
    .core_encrypt_done(a_edone), .core_decrypt_done(a_ddone),
    .dbg_state(a_state)
  );

  bf_job_ctrl #(.TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .rst(rst), .job(jb),
    .core_start(b_start), .core_enc(b_enc), .core_dec(b_dec),
    .core_key(b_key), .core_text(b_text),
    .core_encryptedtext(b_etxt), .core_decryptedtext(b_dtxt),
    .core_encrypt_done(b_edone), .core_decrypt_done(b_ddone),
    .dbg_state(b_state)
  );

  // Core model A: done 16 cycles after start, drops when the mode is released.
  logic a_run = 1'b0, a_rdec = 1'b0, a_stuck = 1'b0, a_corrupt = 1'b0;
  int   a_cnt = 0;
  always_ff @(posedge clk) begin
    if (a_start) begin
      a_run  <= 1'b1;
      a_rdec <= a_dec;
      a_cnt  <= 1;
    end else begin
      if (a_run && a_cnt < 16) a_cnt <= a_cnt + 1;
      if (a_rdec ? !a_dec : !a_enc) a_run <= 1'b0;
    end
  end
  assign a_edone = a_stuck | (a_run & ~a_rdec & a_enc & (a_cnt == 16));
  assign a_ddone = a_stuck | (a_run & a_rdec & a_dec & (a_cnt == 16));
  assign a_etxt  = a_text ^ a_key;
  assign a_dtxt  = a_text ^ a_key ^ {63'd0, a_corrupt};

  // Core model B: done 4 cycles after start unless b_never is set.
  logic b_run = 1'b0, b_rdec = 1'b0, b_never = 1'b0;
  int   b_cnt = 0;
  always_ff @(posedge clk) begin
    if (b_start) begin
      b_run  <= 1'b1;
      b_rdec <= b_dec;
      b_cnt  <= 1;
    end else begin
      if (b_run && b_cnt < 4) b_cnt <= b_cnt + 1;
      if (b_rdec ? !b_dec : !b_enc) b_run <= 1'b0;
    end
  end
  assign b_edone = ~b_never & b_run & ~b_rdec & b_enc & (b_cnt == 4);
  assign b_ddone = ~b_never & b_run & b_rdec & b_dec & (b_cnt == 4);
  assign b_etxt  = b_text ^ b_key;
  assign b_dtxt  = b_text ^ b_key;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks: called at a negedge, return at the negedge where out_valid is first seen
  task automatic a_job(input logic m, input logic [63:0] k, input logic [63:0] d, output int lat);
    int n;
    n = 0;
    while (ja.in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("a_ready_before_job", ja.in_ready, 1);
    ja.in_valid = 1'b1; ja.in_mode = m; ja.in_key = k; ja.in_data = d;
    @(negedge clk);
    ja.in_valid = 1'b0;
    lat = 1;
    while (ja.out_valid !== 1'b1 && lat < 2000) begin @(negedge clk); lat++; end
  endtask

  task automatic b_job(input logic m, input logic [63:0] k, input logic [63:0] d, output int lat);
    int n;
    n = 0;
    while (jb.in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("b_ready_before_job", jb.in_ready, 1);
    jb.in_valid = 1'b1; jb.in_mode = m; jb.in_key = k; jb.in_data = d;
    @(negedge clk);
    jb.in_valid = 1'b0;
    lat = 1;
    while (jb.out_valid !== 1'b1 && lat < 2000) begin @(negedge clk); lat++; end
  endtask

  task automatic a_ack();
    ja.out_ready = 1'b1;
    @(negedge clk);
    ja.out_ready = 1'b0;
    check("a_ready_after_ack", ja.in_ready, 1);
    check("a_valid_after_ack", ja.out_valid, 0);
  endtask

  task automatic b_ack();
    jb.out_ready = 1'b1;
    @(negedge clk);
    jb.out_ready = 1'b0;
    check("b_ready_after_ack", jb.in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int lat;
    int n;
    ja.in_valid = 1'b0; ja.in_mode = 1'b0; ja.in_key = '0; ja.in_data = '0; ja.out_ready = 1'b0;
    jb.in_valid = 1'b0; jb.in_mode = 1'b0; jb.in_key = '0; jb.in_data = '0; jb.out_ready = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", ja.in_ready, 0);
    check("rst_out_valid", ja.out_valid, 0);
    check("rst_out_data", ja.out_data, 0);
    check("rst_core_start", a_start, 0);
    check("rst_core_enc_dec", {a_enc, a_dec}, 0);
    check("rst_core_key", a_key, 0);
    check("rst_state", a_state, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", ja.in_ready, 1);
    check("post_rst_b_in_ready", jb.in_ready, 1);

    // encrypt
    exp_q.push_back(C);
    a_job(1'b0, K, P, lat);
    check("enc_latency", lat, ENC_LAT);
    check("enc_data", ja.out_data, exp_q.pop_front());
    check("enc_err", ja.out_err, 0);
    check("enc_mode", ja.out_mode, 0);
    check("enc_hold_mode_off", {a_enc, a_dec}, 0);
    a_ack();

    // decrypt, then hold with out_ready low for 5 cycles while a new job waits
    exp_q.push_back(P);
    a_job(1'b1, K, C, lat);
    check("dec_latency", lat, 18);
    check("dec_data", ja.out_data, exp_q.pop_front());
    check("dec_mode", ja.out_mode, 1);
    check("dec_err", ja.out_err, 0);
    ja.in_valid = 1'b1; ja.in_mode = 1'b0; ja.in_key = K2; ja.in_data = P;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", ja.out_valid, 1);
      check("hold_data", ja.out_data, P);
      check("hold_mode_err", {ja.out_mode, ja.out_err}, 2'b10);
      check("hold_in_ready", ja.in_ready, 0);
      check("hold_state", a_state, 5);
    end
    ja.out_ready = 1'b1;
    @(negedge clk);
    ja.out_ready = 1'b0;
    check("hold_release_ready", ja.in_ready, 1);
    check("hold_release_state", a_state, 0);
    @(negedge clk);
    ja.in_valid = 1'b0;
    check("queued_job_launch", a_state, 1);
    check("queued_job_start", a_start, 1);
    check("queued_job_key", a_key, K2);
    n = 0;
    while (ja.out_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check("queued_job_data", ja.out_data, R2);
    check("queued_job_err", ja.out_err, 0);
    a_ack();

    // reset in WAIT with done stuck high
    ja.in_valid = 1'b1; ja.in_mode = 1'b0; ja.in_key = K; ja.in_data = P;
    @(negedge clk);
    ja.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_state_wait", a_state, 2);
    a_stuck = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_out_valid", ja.out_valid, 0);
    check("mid_rst_out_data", ja.out_data, 0);
    check("mid_rst_mode_err", {ja.out_mode, ja.out_err}, 0);
    check("mid_rst_core_enc_dec", {a_enc, a_dec, a_start}, 0);
    check("mid_rst_core_ops", {a_key, a_text}, 0);
    check("mid_rst_in_ready", ja.in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_in_ready", ja.in_ready, 1);
    ja.in_valid = 1'b1; ja.in_mode = 1'b1; ja.in_key = K2; ja.in_data = P;
    @(negedge clk);
    ja.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stuck_no_start", a_start, 0);
      check("stuck_launch_state", a_state, 1);
      @(negedge clk);
    end
    a_stuck = 1'b0;
    #1;
    check("unstuck_start", a_start, 1);
    n = 0;
    while (ja.out_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check("after_rst_data", ja.out_data, R2);
    check("after_rst_mode", ja.out_mode, 1);
    a_ack();

`ifdef BF_ROUNDTRIP_CHECK_EN
    // round-trip verify with a corrupted decrypt result
    a_corrupt = 1'b1;
    a_job(1'b0, K, P, lat);
    check("rt_bad_latency", lat, ENC_LAT);
    check("rt_bad_err", ja.out_err, 1);
    check("rt_bad_data", ja.out_data, C);
    a_ack();
    a_corrupt = 1'b0;
`endif

    // watchdog with the short-timeout instance
    b_never = 1'b1;
    b_job(1'b0, K, P, lat);
    check("to_latency", lat, 10);
    check("to_err", jb.out_err, 1);
    check("to_data", jb.out_data, 0);
    check("to_mode", jb.out_mode, 0);
    b_ack();
    b_never = 1'b0;
    b_job(1'b1, K, C, lat);
    check("after_to_latency", lat, 6);
    check("after_to_data", jb.out_data, P);
    check("after_to_err", jb.out_err, 0);
    b_ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
